// File: rtl/weight_fifo_pkg.sv
// Shared definitions for the weight FIFO bank: fill-FSM state encoding and
// default geometry used by the input controller, output controller and bank.
package weight_fifo_pkg;

  localparam int unsigned DEF_FIFO_WIDTH = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 16;
  localparam int unsigned DEF_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DRAIN = 2'd3
  } fill_state_e;

endpackage : weight_fifo_pkg

// File: rtl/weight_fifo_in_ctrl_if.sv
// Bundle between the weight-fill controller and its surroundings.
// master : upstream row source + FIFO bank + output controller (environment)
// slave  : weight_fifo_in_ctrl
//   start/col_mask   tile start request and column enable mask
//   in_valid/in_ready/in_data   row stream, one row per beat
//   fifo_full/fifo_push/fifo_wdata   per-column FIFO bank write port
//   out_en/out_done  handshake with the FIFO output controller
//   busy/tile_done   status
interface weight_fifo_in_ctrl_if
  import weight_fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                             start;
  logic [FIFO_WIDTH-1:0]            col_mask;
  logic                             in_valid;
  logic                             in_ready;
  logic [FIFO_WIDTH*DATA_WIDTH-1:0] in_data;
  logic [FIFO_WIDTH-1:0]            fifo_full;
  logic [FIFO_WIDTH-1:0]            fifo_push;
  logic [FIFO_WIDTH*DATA_WIDTH-1:0] fifo_wdata;
  logic                             out_en;
  logic                             out_done;
  logic                             busy;
  logic                             tile_done;

  modport master (
    output start, col_mask, in_valid, in_data, fifo_full, out_done,
    input  in_ready, fifo_push, fifo_wdata, out_en, busy, tile_done
  );

  modport slave (
    input  start, col_mask, in_valid, in_data, fifo_full, out_done,
    output in_ready, fifo_push, fifo_wdata, out_en, busy, tile_done
  );

endinterface : weight_fifo_in_ctrl_if

// File: rtl/weight_fifo_in_ctrl.sv
// Upstream fill controller for the weight FIFO bank. Accepts FIFO_DEPTH rows
// on a valid/ready stream, pushes each row into the masked-in column FIFOs,
// pulses out_en to the output controller, then waits for its out_done.
// Ports:
//   clk   clock
//   rstn  asynchronous active-low reset
//   bus   weight_fifo_in_ctrl_if.slave (stream, FIFO bank, output ctrl, status)
// in_ready, fifo_push and fifo_wdata are combinational decodes of the
// registered state; out_en, busy and tile_done come straight from flops.
module weight_fifo_in_ctrl
  import weight_fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  weight_fifo_in_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(FIFO_DEPTH - 1);

  fill_state_e           state_q, state_d;
  logic [CNT_W-1:0]      row_cnt_q, row_cnt_d;
  logic [FIFO_WIDTH-1:0] mask_q, mask_d;
  logic                  out_en_q, out_en_d;
  logic                  busy_q, busy_d;
  logic                  tile_done_q, tile_done_d;

  logic                  in_ready_c;
  logic                  beat_c;

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    mask_d      = mask_q;
    out_en_d    = 1'b0;
    tile_done_d = 1'b0;
    in_ready_c  = 1'b0;
    beat_c      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // The tile_done cycle is already IDLE but still closes the previous
        // tile, so a start landing on it is dropped.
        if (bus.start && !tile_done_q) begin
          state_d   = ST_FILL;
          row_cnt_d = '0;
          mask_d    = bus.col_mask;
        end
      end

      ST_FILL: begin
        // Only masked-in columns may stall the stream.
        in_ready_c = ~|(bus.fifo_full & mask_q);
        beat_c     = bus.in_valid && in_ready_c;
        if (beat_c) begin
          if (row_cnt_q == LAST_ROW) begin
            row_cnt_d = '0;
            state_d   = ST_ISSUE;
            out_en_d  = 1'b1;
          end else begin
            row_cnt_d = row_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_ISSUE: begin
        state_d = ST_DRAIN;
      end

      ST_DRAIN: begin
        if (bus.out_done) begin
          state_d     = ST_IDLE;
          tile_done_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      row_cnt_q   <= '0;
      mask_q      <= '0;
      out_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      mask_q      <= mask_d;
      out_en_q    <= out_en_d;
      busy_q      <= busy_d;
      tile_done_q <= tile_done_d;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.fifo_push  = {FIFO_WIDTH{beat_c}} & mask_q;
  // Data is only meaningful in FILL; elsewhere it reads zero.
  assign bus.fifo_wdata = (state_q == ST_FILL) ? bus.in_data : '0;
  assign bus.out_en     = out_en_q;
  assign bus.busy       = busy_q;
  assign bus.tile_done  = tile_done_q;

endmodule : weight_fifo_in_ctrl

// File: tb/tb_weight_fifo_in_ctrl.sv
// Directed bench for weight_fifo_in_ctrl with FIFO_WIDTH=4, FIFO_DEPTH=4,
// DATA_WIDTH=8. Inputs are driven 1ns after the rising edge, outputs are
// sampled 1ns later. Flag vector layout: {in_ready, out_en, busy, tile_done, fifo_push[3:0]}.
module tb_weight_fifo_in_ctrl;

  logic clk;
  logic rstn;
  int   n_vec;
  int   n_err;

  weight_fifo_in_ctrl_if #(.FIFO_WIDTH(4), .DATA_WIDTH(8)) bus ();

  weight_fifo_in_ctrl #(
    .FIFO_WIDTH(4),
    .FIFO_DEPTH(4),
    .DATA_WIDTH(8)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] row_val(int k);
    return {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
  endfunction

  function automatic logic [7:0] snap();
    return {bus.in_ready, bus.out_en, bus.busy, bus.tile_done, bus.fifo_push};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.col_mask  = 4'h0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.fifo_full = 4'h0;
    bus.out_done  = 1'b0;
  endtask

  task automatic test_reset();
    rstn          = 1'b0;
    bus.start     = 1'b1;
    bus.col_mask  = 4'hF;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hDEADBEEF;
    bus.fifo_full = 4'h0;
    bus.out_done  = 1'b1;
    #1;
    n_vec++;
    if (snap() !== 8'h00) begin
      n_err++; $display("FAIL reset_t0 flags obs=%h exp=00", snap());
    end
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (snap() !== 8'h00 || bus.fifo_wdata !== 32'h0) begin
      n_err++; $display("FAIL reset_held flags obs=%h wdata=%h exp=00/0", snap(), bus.fifo_wdata);
    end
    idle_inputs();
    rstn = 1'b1;
    #1;
    n_vec++;
    if (snap() !== 8'h00) begin
      n_err++; $display("FAIL reset_release flags obs=%h exp=00", snap());
    end
    next_cycle();
    #1;
    n_vec++;
    if (snap() !== 8'h00) begin
      n_err++; $display("FAIL reset_first_cycle flags obs=%h exp=00", snap());
    end
    next_cycle();
  endtask

  task automatic test_basic();
    logic [7:0] exp;
    for (int c = 0; c <= 11; c++) begin
      bus.start     = (c == 0);
      bus.col_mask  = 4'hF;
      bus.in_valid  = (c <= 5);
      bus.in_data   = row_val((c >= 1 && c <= 4) ? c - 1 : 0);
      bus.fifo_full = 4'h0;
      bus.out_done  = (c == 9);
      #1;
      if (c >= 1 && c <= 4)      exp = 8'hAF;
      else if (c == 5)           exp = 8'h60;
      else if (c >= 6 && c <= 9) exp = 8'h20;
      else if (c == 10)          exp = 8'h10;
      else                       exp = 8'h00;
      n_vec++;
      if (snap() !== exp) begin
        n_err++; $display("FAIL basic c%0d flags obs=%h exp=%h", c, snap(), exp);
      end
      if (c >= 1 && c <= 4) begin
        n_vec++;
        if (bus.fifo_wdata !== row_val(c - 1)) begin
          n_err++; $display("FAIL basic c%0d wdata obs=%h exp=%h", c, bus.fifo_wdata, row_val(c - 1));
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [7:0] exp;
    int idx;
    for (int c = 0; c <= 11; c++) begin
      if (c <= 1)      idx = 0;
      else if (c == 2) idx = 1;
      else if (c <= 6) idx = 2;
      else             idx = 3;
      bus.start     = (c == 0);
      bus.col_mask  = 4'hF;
      bus.in_valid  = (c <= 7);
      bus.in_data   = row_val(idx);
      bus.fifo_full = (c >= 3 && c <= 5) ? 4'b0100 : 4'b0000;
      bus.out_done  = (c == 9);
      #1;
      if (c == 1 || c == 2 || c == 6 || c == 7) exp = 8'hAF;
      else if (c >= 3 && c <= 5)                exp = 8'h20;
      else if (c == 8)                          exp = 8'h60;
      else if (c == 9)                          exp = 8'h20;
      else if (c == 10)                         exp = 8'h10;
      else                                      exp = 8'h00;
      n_vec++;
      if (snap() !== exp) begin
        n_err++; $display("FAIL backpressure c%0d flags obs=%h exp=%h", c, snap(), exp);
      end
      if (exp == 8'hAF) begin
        n_vec++;
        if (bus.fifo_wdata !== row_val(idx)) begin
          n_err++; $display("FAIL backpressure c%0d wdata obs=%h exp=%h", c, bus.fifo_wdata, row_val(idx));
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_masking();
    logic [7:0] exp;
    logic [3:0] masks [2];
    masks[0] = 4'b0101;
    masks[1] = 4'b0000;
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c <= 8; c++) begin
        bus.start     = (c == 0);
        bus.col_mask  = masks[m];
        bus.in_valid  = (c <= 5);
        bus.in_data   = row_val((c >= 1 && c <= 4) ? c - 1 : 0);
        bus.fifo_full = 4'b0010;
        bus.out_done  = (c == 6);
        #1;
        if (c >= 1 && c <= 4) exp = {4'hA, masks[m]};
        else if (c == 5)      exp = 8'h60;
        else if (c == 6)      exp = 8'h20;
        else if (c == 7)      exp = 8'h10;
        else                  exp = 8'h00;
        n_vec++;
        if (snap() !== exp) begin
          n_err++; $display("FAIL masking m%h c%0d flags obs=%h exp=%h", masks[m], c, snap(), exp);
        end
        next_cycle();
      end
    end
    idle_inputs();
  endtask

  task automatic test_ignored();
    logic [7:0] exp;
    int idx;
    for (int c = 0; c <= 19; c++) begin
      if (c == 3)                 idx = 1;
      else if (c == 4)            idx = 2;
      else if (c == 5)            idx = 3;
      else if (c >= 12 && c <= 15) idx = c - 12;
      else                        idx = 0;
      bus.start     = (c == 0 || c == 2 || c == 7 || c == 10 || c == 11);
      bus.col_mask  = 4'hF;
      bus.in_valid  = (c == 1) || (c >= 3 && c <= 5) || (c >= 12 && c <= 15);
      bus.in_data   = row_val(idx);
      bus.fifo_full = 4'h0;
      bus.out_done  = (c == 2 || c == 9 || c == 17);
      #1;
      if (c == 1 || (c >= 3 && c <= 5) || (c >= 12 && c <= 15)) exp = 8'hAF;
      else if (c == 2)                  exp = 8'hA0;
      else if (c == 6 || c == 16)       exp = 8'h60;
      else if ((c >= 7 && c <= 9) || c == 17) exp = 8'h20;
      else if (c == 10 || c == 18)      exp = 8'h10;
      else                              exp = 8'h00;
      n_vec++;
      if (snap() !== exp) begin
        n_err++; $display("FAIL ignored c%0d flags obs=%h exp=%h", c, snap(), exp);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    int idx;
    int n_oen;
    n_oen = 0;
    for (int c = 0; c <= 13; c++) begin
      if (c == 2)                idx = 1;
      else if (c == 3)           idx = 2;
      else if (c >= 6 && c <= 9) idx = c - 6;
      else                       idx = 0;
      rstn          = (c != 3);
      bus.start     = (c == 0 || c == 5);
      bus.col_mask  = 4'hF;
      bus.in_valid  = (c >= 1 && c <= 3) || (c >= 6 && c <= 9);
      bus.in_data   = row_val(idx);
      bus.fifo_full = 4'h0;
      bus.out_done  = (c == 11);
      #1;
      if (c == 1 || c == 2 || (c >= 6 && c <= 9)) exp = 8'hAF;
      else if (c == 10) exp = 8'h60;
      else if (c == 11) exp = 8'h20;
      else if (c == 12) exp = 8'h10;
      else              exp = 8'h00;
      n_vec++;
      if (snap() !== exp) begin
        n_err++; $display("FAIL reset_mid c%0d flags obs=%h exp=%h", c, snap(), exp);
      end
      if (c == 3) begin
        n_vec++;
        if (bus.fifo_wdata !== 32'h0) begin
          n_err++; $display("FAIL reset_mid wdata_in_reset obs=%h exp=0", bus.fifo_wdata);
        end
      end
      if (c >= 6 && c <= 9) begin
        n_vec++;
        if (bus.fifo_wdata !== row_val(idx)) begin
          n_err++; $display("FAIL reset_mid c%0d wdata obs=%h exp=%h", c, bus.fifo_wdata, row_val(idx));
        end
      end
      if (c >= 4 && bus.out_en === 1'b1) n_oen++;
      next_cycle();
    end
    n_vec++;
    if (n_oen !== 1) begin
      n_err++; $display("FAIL reset_mid out_en_count obs=%0d exp=1", n_oen);
    end
    idle_inputs();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_masking();
    test_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_weight_fifo_in_ctrl

// File: doc/weight_fifo_in_ctrl.md
Name: weight_fifo_in_ctrl

Overview:
Upstream fill controller for the weight FIFO bank. It accepts one row of weights per beat on a valid/ready stream and pushes each row into FIFO_WIDTH column FIFOs. After FIFO_DEPTH rows are loaded, it issues a one-cycle enable to the downstream FIFO output controller. It then waits for that controller's done before accepting the next tile.

Parameters:
FIFO_WIDTH, 16, number of column FIFOs (one per PE column)
FIFO_DEPTH, 16, rows per tile (entries per column FIFO)
DATA_WIDTH, 16, bits per weight element

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
start  input  1  begin loading one tile; sampled only in IDLE
col_mask  input  FIFO_WIDTH  column enable mask, latched on accepted start
in_valid  input  1  upstream row valid
in_ready  output  1  row accepted when in_valid && in_ready
in_data  input  FIFO_WIDTH*DATA_WIDTH  one row; column c at bits [c*DATA_WIDTH +: DATA_WIDTH]
fifo_full  input  FIFO_WIDTH  per-column full flags from the FIFO bank
fifo_push  output  FIFO_WIDTH  per-column push strobe
fifo_wdata  output  FIFO_WIDTH*DATA_WIDTH  row data to FIFO bank
out_en  output  1  one-cycle start pulse to the FIFO output controller
out_done  input  1  drain-complete pulse from the FIFO output controller
busy  output  1  high in any state except IDLE
tile_done  output  1  one-cycle pulse when a tile has been filled and drained

Behaviour:
- Reset is asynchronous on the falling edge of rstn. It forces state to IDLE, row_cnt=0 and mask_q=0. All outputs read 0 while rstn=0 and on the first cycle after release.
- Reset mid-fill or mid-drain abandons the tile. Partial FIFO contents are not cleaned up; the FIFO bank resets on the same rstn.
- row_cnt width is $clog2(FIFO_DEPTH+1). It never exceeds FIFO_DEPTH.
- The FSM has four states, registered: IDLE, FILL, ISSUE, DRAIN.
- IDLE:
  - in_ready=0, busy=0.
  - When start=1, go to FILL; row_cnt<=0; mask_q<=col_mask.
- FILL:
  - in_ready = ~|(fifo_full & mask_q). Only masked-in columns apply backpressure.
  - beat = in_valid && in_ready.
  - fifo_push = {FIFO_WIDTH{beat}} & mask_q, combinational (same cycle as beat).
  - fifo_wdata = in_data, combinational pass-through.
  - Each beat increments row_cnt. The beat taken with row_cnt==FIFO_DEPTH-1 moves the FSM to ISSUE; row_cnt<=0.
  - in_valid with in_ready=0 produces no push and no count change.
- ISSUE:
  - out_en=1 for exactly this one cycle; in_ready=0. Go to DRAIN unconditionally.
- DRAIN:
  - in_ready=0. Wait for out_done=1, then go to IDLE and assert tile_done=1 for the cycle after out_done (registered pulse).
- Signals ignored outside their state:
  - start outside IDLE, including the cycle tile_done is high, is ignored. A new start is accepted on the first IDLE cycle.
  - out_done outside DRAIN is ignored.
- col_mask=0 on start: the FSM still counts FIFO_DEPTH beats. in_ready is 1 and no pushes occur.
- FIFO_DEPTH=1: a single beat goes FILL->ISSUE.
- Minimum tile latency, with in_valid held high and no full flags: 1 (start) + FIFO_DEPTH (FILL) + 1 (ISSUE) + drain cycles + 1 (tile_done).
- fifo_wdata need not be zero when no push is issued.

Decomposition:
- weight_fifo_pkg holds:
  - the typedef enum logic [1:0] for the state encoding {IDLE, FILL, ISSUE, DRAIN};
  - default constants for FIFO_WIDTH, FIFO_DEPTH and DATA_WIDTH, shared with the FIFO output controller and the FIFO bank.
- No sub-module: the FSM plus row counter is one module, 120-200 lines.

Test Plan:
Common setup: FIFO_WIDTH=4, FIFO_DEPTH=4, DATA_WIDTH=8.
1. Basic tile: start, col_mask=4'hF; in_valid held high with rows 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; no full flags. -> fifo_push=4'hF on cycles 1-4 with matching fifo_wdata; out_en on cycle 5; busy=1 from cycle 1. Then out_done at cycle 9 -> tile_done=1 at cycle 10, busy=0 at cycle 10.
2. Backpressure: fifo_full[2]=1 during beat 2 for 3 cycles. -> in_ready=0 and fifo_push=0 for those 3 cycles; row 2 is pushed exactly once afterwards; out_en is delayed by 3 cycles.
3. Masking: col_mask=4'b0101 with fifo_full[1]=1 throughout. -> in_ready stays 1; fifo_push=4'b0101 on every beat; 4 beats still reach ISSUE.
4. Ignored inputs: start pulsed during FILL and DRAIN, out_done pulsed during FILL. -> no state change, row_cnt unaffected, no extra out_en. A start on the cycle after tile_done begins a new tile.
5. Reset mid-operation: rstn low after 2 beats, for 1 cycle. -> all outputs 0 immediately (async). After release the FSM is in IDLE; a new start loads a full 4-row tile and gives exactly one out_en.
